// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with glitch-free, period-boundary config apply.
// Optional CLK_DIV_SYNC_EN adds a sync_in strobe that phase-aligns all enabled channels.
module clk_div_prog #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CH_W     = 1,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DEF_DIV  = 4,
  parameter int unsigned DEF_HIGH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
`ifdef CLK_DIV_SYNC_EN
  input  logic              sync_in,
`endif
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] ch_tick
);

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  div_a_q  [NUM_CH];
  logic [CNT_W-1:0]  div_a_d  [NUM_CH];
  logic [CNT_W-1:0]  high_a_q [NUM_CH];
  logic [CNT_W-1:0]  high_a_d [NUM_CH];
  logic [CNT_W-1:0]  div_p_q  [NUM_CH];
  logic [CNT_W-1:0]  div_p_d  [NUM_CH];
  logic [CNT_W-1:0]  high_p_q [NUM_CH];
  logic [CNT_W-1:0]  high_p_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              err_q, err_d;
  logic              cfg_legal_c;
  logic              sync_c;

`ifdef CLK_DIV_SYNC_EN
  assign sync_c = sync_in;
`else
  assign sync_c = 1'b0;
`endif

  assign cfg_legal_c = (cfg_div >= CNT_W'(2)) && (cfg_high >= CNT_W'(1)) &&
                       (cfg_high < cfg_div) && (32'(cfg_ch) < 32'(NUM_CH));

  // Next-state: pending apply at wrap/restart/disable, then a new write lands in pending
  always_comb begin
    err_d = cfg_wr && !cfg_legal_c;
    en_d  = ch_en;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]     = cnt_q[i];
      div_a_d[i]   = div_a_q[i];
      high_a_d[i]  = high_a_q[i];
      div_p_d[i]   = div_p_q[i];
      high_p_d[i]  = high_p_q[i];
      pend_d[i]    = pend_q[i];
      clk_out_d[i] = clk_out_q[i];
      tick_d[i]    = tick_q[i];

      if (!ch_en[i]) begin
        if (pend_q[i]) begin
          div_a_d[i]  = div_p_q[i];
          high_a_d[i] = high_p_q[i];
          pend_d[i]   = 1'b0;
        end
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
        tick_d[i]    = 1'b0;
      end else if (!en_q[i] || sync_c || (cnt_q[i] == CNT_W'(div_a_q[i] - CNT_W'(1)))) begin
        // Period boundary: high time is always >= 1, so the new period starts high
        if (pend_q[i]) begin
          div_a_d[i]  = div_p_q[i];
          high_a_d[i] = high_p_q[i];
          pend_d[i]   = 1'b0;
        end
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b1;
        tick_d[i]    = 1'b1;
      end else begin
        cnt_d[i]     = CNT_W'(cnt_q[i] + CNT_W'(1));
        clk_out_d[i] = (CNT_W'(cnt_q[i] + CNT_W'(1)) < high_a_q[i]);
        tick_d[i]    = 1'b0;
      end

      if (cfg_wr && cfg_legal_c && (cfg_ch == CH_W'(i))) begin
        div_p_d[i]  = cfg_div;
        high_p_d[i] = cfg_high;
        pend_d[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        div_a_q[i]  <= CNT_W'(DEF_DIV);
        high_a_q[i] <= CNT_W'(DEF_HIGH);
        div_p_q[i]  <= CNT_W'(DEF_DIV);
        high_p_q[i] <= CNT_W'(DEF_HIGH);
      end
      pend_q    <= '0;
      en_q      <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        div_a_q[i]  <= div_a_d[i];
        high_a_q[i] <= high_a_d[i];
        div_p_q[i]  <= div_p_d[i];
        high_p_q[i] <= high_p_d[i];
      end
      pend_q    <= pend_d;
      en_q      <= en_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  assign cfg_err = err_q;
  assign clk_out = clk_out_q;
  assign ch_tick = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog (default build, 2 channels, div 4 / high 2 at reset).
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ch_en;
  logic       cfg_wr;
  logic       cfg_ch;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic       cfg_err;
  logic [1:0] clk_out;
  logic [1:0] ch_tick;
`ifdef CLK_DIV_SYNC_EN
  logic       sync_in = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic       err;
    logic [1:0] co;
    logic [1:0] tk;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  int m_cnt [2];
  int m_div [2];
  int m_high[2];
  int m_dp  [2];
  int m_hp  [2];
  bit m_pend[2];
  bit m_en  [2];

  always #5 clk = ~clk;

  clk_div_prog dut (
    .clk      (clk),
    .rst      (rst),
    .ch_en    (ch_en),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
`ifdef CLK_DIV_SYNC_EN
    .sync_in  (sync_in),
`endif
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .ch_tick  (ch_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one edge with the given inputs and return the outputs it predicts
  task automatic model_edge(input bit r, input bit [1:0] en, input bit wr, input bit ch,
                            input int dv, input int hi, output exp_t e);
    bit legal;
    e = '0;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_div[i] = 4; m_high[i] = 2; m_pend[i] = 0; m_en[i] = 0;
      end
      return;
    end
    legal = (dv >= 2) && (hi >= 1) && (hi < dv);
    e.err = wr && !legal;
    for (int i = 0; i < 2; i++) begin
      bool_step(i, en[i]);
      e.co[i] = en[i] && (m_cnt[i] < m_high[i]);
      e.tk[i] = en[i] && (m_cnt[i] == 0);
      if (wr && legal && (int'(ch) == i)) begin
        m_dp[i] = dv; m_hp[i] = hi; m_pend[i] = 1;
      end
    end
  endtask

  task automatic bool_step(input int i, input bit en);
    bit boundary;
    boundary = !en || !m_en[i] || (m_cnt[i] + 1 == m_div[i]);
    if (boundary && m_pend[i]) begin
      m_div[i] = m_dp[i]; m_high[i] = m_hp[i]; m_pend[i] = 0;
    end
    m_cnt[i] = boundary ? 0 : m_cnt[i] + 1;
    m_en[i]  = en;
  endtask

  task automatic cycle(input bit r, input bit [1:0] en, input bit wr, input bit ch,
                       input int dv, input int hi);
    exp_t e, got;
    @(negedge clk);
    rst = r; ch_en = en; cfg_wr = wr; cfg_ch = ch;
    cfg_div = 8'(dv); cfg_high = 8'(hi);
    model_edge(r, en, wr, ch, dv, hi, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("cfg_err", 32'(cfg_err), 32'(got.err));
    chk("clk_out", 32'(clk_out), 32'(got.co));
    chk("ch_tick", 32'(ch_tick), 32'(got.tk));
  endtask

  task automatic idle(input bit [1:0] en, input int n);
    for (int k = 0; k < n; k++) cycle(0, en, 0, 0, 0, 0);
  endtask

  initial begin
    logic [3:0] pat;
    pat = 4'b0011;
    rst = 1'b1; ch_en = '0; cfg_wr = 0; cfg_ch = 0; cfg_div = '0; cfg_high = '0;

    // Reset state
    cycle(1, 2'b00, 0, 0, 0, 0);
    cycle(1, 2'b00, 0, 0, 0, 0);
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(ch_tick), 32'd0);

    // Default 4/2 waveform on ch0: 1,1,0,0; ch1 idle
    for (int k = 0; k < 8; k++) begin
      cycle(0, 2'b01, 0, 0, 0, 0);
      chk("t1_pattern", 32'(clk_out[0]), 32'(pat[k % 4]));
      chk("t1_ch1_low", 32'(clk_out[1]), 32'd0);
    end

    // Mid-period write 5/1: old period completes then 1 high / 4 low
    cycle(0, 2'b01, 1, 0, 5, 1);
    idle(2'b01, 12);

    // Illegal writes: high == div, div < 2 and high == 0
    cycle(0, 2'b01, 1, 0, 3, 3);
    chk("t3_err_a", 32'(cfg_err), 32'd1);
    cycle(0, 2'b01, 1, 0, 1, 0);
    chk("t3_err_b", 32'(cfg_err), 32'd1);
    cycle(0, 2'b01, 1, 0, 9, 0);
    idle(2'b01, 6);

    // Back-to-back writes before wrap: last wins
    cycle(0, 2'b01, 1, 0, 6, 3);
    cycle(0, 2'b01, 1, 0, 8, 2);
    idle(2'b01, 18);

    // Enable drop mid-high and restart
    while (!(dut.clk_out[0] && dut.ch_tick[0])) idle(2'b01, 1);
    cycle(0, 2'b00, 0, 0, 0, 0);
    chk("t5_drop", 32'(clk_out[0]), 32'd0);
    idle(2'b00, 2);
    cycle(0, 2'b01, 0, 0, 0, 0);
    chk("t5_restart", 32'({clk_out[0], ch_tick[0]}), 32'd3);
    idle(2'b01, 9);

    // Write to a disabled channel then enable both
    cycle(0, 2'b01, 1, 1, 3, 1);
    idle(2'b11, 12);

    // Random traffic on both channels, mixing legal and illegal writes
    for (int k = 0; k < 300; k++) begin
      bit [1:0] en;
      en = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b11;
      if ($urandom_range(0, 5) == 0)
        cycle(0, en, 1, 1'($urandom), int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
      else
        cycle(0, en, 0, 0, 0, 0);
    end

    // Reset mid-period discards pending and restores defaults
    cycle(0, 2'b11, 1, 0, 7, 3);
    cycle(1, 2'b11, 0, 0, 0, 0);
    chk("rst_mid", 32'({clk_out, ch_tick}), 32'd0);
    idle(2'b11, 10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
